result_accumulator: RTL
=======================

// Module: result_accumulator
// PURPOSE
//  Downstream of the systolic array: consumes its skewed partial-sum vector, de-skews lanes,
//  accumulates rows over successive weight tiles into an on-block accumulator bank, then drains
//  the bank row-by-row into the result SRAM write port. Enables K-dimension tiling.
// PARAMETERS
//  PARTIAL_SUM_BW  20  width of one signed result lane from the array
//  MATRIX_SIZE     8   lanes per result vector (array columns)
//  ACC_BW          24  signed accumulator width per lane, > PARTIAL_SUM_BW
//  ACC_DEPTH       8   rows per tile = accumulator entries
//  ADDR_BW         3   wr_addr width, clog2(ACC_DEPTH)
// PORTS
//  clk          in   1                         clock
//  rstn         in   1                         async active-low reset
//  start        in   1                         pulse: begin collecting one tile
//  acc_clear    in   1                         sampled with start: 1=overwrite, 0=add to bank
//  result_valid in   1                         lane 0 of result_in valid this cycle
//  result_in    in   PARTIAL_SUM_BW*MATRIX_SIZE skewed signed lanes; lane c valid c cycles after lane 0
//  drain        in   1                         pulse: write bank out
//  wr_en        out  1                         result SRAM write strobe
//  wr_addr      out  ADDR_BW                   result SRAM row address
//  wr_data      out  ACC_BW*MATRIX_SIZE        result SRAM row data, lane 0 in LSBs
//  busy         out  1                         state != IDLE
//  tile_done    out  1                         1-cycle pulse, tile fully accumulated
//  done         out  1                         1-cycle pulse, drain complete
// BEHAVIOUR
//  - Reset (async): state IDLE, all outputs 0, accumulator bank 0, de-skew pipes 0, counters 0.
//  - De-skew: lane c delayed MATRIX_SIZE-1-c cycles, result_valid delayed MATRIX_SIZE-1; yields
//    aligned vector + aligned valid. Pipes shift every cycle regardless of state.
//  - FSM IDLE/COLLECT/DRAIN.
//    IDLE: start -> COLLECT, row_cnt=0, latch acc_clear. drain (no start) -> DRAIN, drain_cnt=0.
//          start and drain same cycle: start wins, drain dropped.
//    COLLECT: per aligned valid, acc[row_cnt] <= clear ? sat(sext(x)) : sat(acc[row_cnt]+x),
//          row_cnt++. Aligned valid with row_cnt==ACC_DEPTH-1 -> IDLE, tile_done next cycle.
//    DRAIN: each cycle wr_en=1, wr_addr=drain_cnt, wr_data=acc[drain_cnt]; ACC_DEPTH consecutive
//          writes, addr 0..ACC_DEPTH-1, then IDLE; done pulses cycle after last wr_en.
//  - start/drain outside IDLE ignored. Aligned valid outside COLLECT dropped, bank untouched.
//  - start must be on/before first result_valid of the tile.
//  - Arithmetic: per-lane signed, sext to ACC_BW+1, add, clamp to [-2^(ACC_BW-1), 2^(ACC_BW-1)-1].
//  - Latency: lane 0 at cycle t -> bank updated at t+MATRIX_SIZE; drain sampled at t -> first
//    wr_en at t+1, done at t+ACC_DEPTH+1.
//  - Bank not cleared by drain; next tile's acc_clear=1 overwrites.
//  - Reset mid-COLLECT/DRAIN: immediate abort, wr_en low at once, no done/tile_done.
//  - All outputs registered.
// CONFIGURATION
//  RESULT_ACC_RELU_EN defined: drained lanes pass ReLU (negative -> 0); bank keeps raw values.
//  Undefined: wr_data is raw saturated accumulator contents.
// STRUCTURE
//  Shared package tpu_result_pkg: FSM state encoding (IDLE/COLLECT/DRAIN), ACC_MAX/ACC_MIN
//  localparams, sat_add function, lane slice helper.
//  Sub-module result_deskew: parameterised per-lane delay line + valid delay, instantiated once.
// TESTING
//  1 Reset: rstn=0 mid-run -> all outputs 0 next edge; then drain -> 8 writes of all-zero data.
//  2 Tile acc_clear=1, row r lane c = 10r+c skewed -> tile_done 1 cycle after last aligned row;
//    drain -> wr_addr 0..7, lane c of row r = 10r+c, done 1 cycle after addr 7.
//  3 Repeat same tile with acc_clear=0 -> drain lanes = 2*(10r+c).
//  4 ACC_BW=21: three tiles of +524287 -> 1048575 clamped; three of -524288 -> -1048576.
//  5 start+drain same IDLE cycle -> COLLECT, no wr_en; start during DRAIN ignored, 8 writes exact.
//  6 RESULT_ACC_RELU_EN: lane -5 drains 0; undefined: drains 24'hFFFFFB.

Source files
------------

// File: rtl/tpu_result_pkg.sv
// Shared definitions for the result accumulator: FSM encoding, default
// geometry, saturation limits, a saturating adder and a lane slice helper.
package tpu_result_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } acc_state_e;

  localparam int DEF_PSUM_BW     = 20;
  localparam int DEF_MATRIX_SIZE = 8;
  localparam int DEF_ACC_BW      = 24;
  localparam int DEF_ACC_DEPTH   = 8;
  localparam int DEF_ADDR_BW     = 3;

  // Wide enough to hold any lane sum before clamping.
  localparam int SAT_W = 64;

  localparam logic signed [DEF_ACC_BW-1:0] ACC_MAX = {1'b0, {(DEF_ACC_BW-1){1'b1}}};
  localparam logic signed [DEF_ACC_BW-1:0] ACC_MIN = {1'b1, {(DEF_ACC_BW-1){1'b0}}};

  // Add two sign-extended operands and clamp to the signed range of bw bits.
  function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a,
                                                      input logic signed [SAT_W-1:0] b,
                                                      input int bw);
    logic signed [SAT_W-1:0] sum_v;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sum_v = a + b;
    max_v = (64'sd1 <<< (bw - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (bw - 1));
    if (sum_v > max_v) begin
      return max_v;
    end else if (sum_v < min_v) begin
      return min_v;
    end else begin
      return sum_v;
    end
  endfunction

  // Bit offset of a lane inside a packed lane vector.
  function automatic int lane_lsb(input int lane, input int bw);
    return lane * bw;
  endfunction

endpackage

// File: rtl/result_deskew.sv
// Re-aligns the skewed output of the systolic array: lane c arrives c cycles
// after lane 0, so it is delayed LANES-1-c cycles; the valid follows lane 0
// and is delayed LANES-1 cycles. The pipes shift every cycle.
module result_deskew
  import tpu_result_pkg::*;
#(
  parameter int LANE_BW = DEF_PSUM_BW,
  parameter int LANES   = DEF_MATRIX_SIZE
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     valid_in,
  input  logic [LANE_BW*LANES-1:0] data_in,
  output logic                     aligned_valid,
  output logic [LANE_BW*LANES-1:0] aligned_data
);

  logic vld_pipe_r [LANES-1];

  // Valid delay line tracking lane 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LANES - 1; i++) vld_pipe_r[i] <= 1'b0;
    end else begin
      vld_pipe_r[0] <= valid_in;
      for (int i = 1; i < LANES - 1; i++) vld_pipe_r[i] <= vld_pipe_r[i-1];
    end
  end

  assign aligned_valid = vld_pipe_r[LANES-2];

  for (genvar c = 0; c < LANES; c++) begin : g_lane
    localparam int DLY = LANES - 1 - c;
    localparam int LSB = lane_lsb(c, LANE_BW);
    if (DLY == 0) begin : g_pass
      assign aligned_data[LSB +: LANE_BW] = data_in[LSB +: LANE_BW];
    end else begin : g_pipe
      logic [LANE_BW-1:0] pipe_r [DLY];

      // Per-lane delay line of DLY stages.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < DLY; i++) pipe_r[i] <= '0;
        end else begin
          pipe_r[0] <= data_in[LSB +: LANE_BW];
          for (int i = 1; i < DLY; i++) pipe_r[i] <= pipe_r[i-1];
        end
      end

      assign aligned_data[LSB +: LANE_BW] = pipe_r[DLY-1];
    end
  end

endmodule

// File: rtl/result_accumulator.sv
// Result accumulator: de-skews the systolic array output, accumulates one
// tile of rows into a saturating accumulator bank (overwrite or add), and
// drains the bank row by row to the result SRAM write port.
// Optional feature macro: RESULT_ACC_RELU_EN applies ReLU to drained lanes
// (the bank itself keeps raw values).
module result_accumulator
  import tpu_result_pkg::*;
#(
  parameter int PARTIAL_SUM_BW = DEF_PSUM_BW,
  parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
  parameter int ACC_BW         = DEF_ACC_BW,
  parameter int ACC_DEPTH      = DEF_ACC_DEPTH,
  parameter int ADDR_BW        = DEF_ADDR_BW
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic                              acc_clear,
  input  logic                              result_valid,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] result_in,
  input  logic                              drain,
  output logic                              wr_en,
  output logic [ADDR_BW-1:0]                wr_addr,
  output logic [ACC_BW*MATRIX_SIZE-1:0]     wr_data,
  output logic                              busy,
  output logic                              tile_done,
  output logic                              done
);

  localparam int ROW_W = ACC_BW * MATRIX_SIZE;
  localparam logic [ADDR_BW-1:0] LAST_ROW = ADDR_BW'(ACC_DEPTH - 1);

  acc_state_e                        state_r;
  logic [ADDR_BW-1:0]                row_cnt_r;
  logic                              clear_r;
  logic                              wr_en_r;
  logic [ADDR_BW-1:0]                wr_addr_r;
  logic [ROW_W-1:0]                  wr_data_r;
  logic                              busy_r;
  logic                              tile_done_r;
  logic                              done_r;
  logic [ROW_W-1:0]                  bank_r [ACC_DEPTH];

  logic                              al_valid_s;
  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] al_data_s;
  logic                              bank_we_s;
  logic [ROW_W-1:0]                  bank_wdata_s;
  logic [ROW_W-1:0]                  cur_row_s;
  logic [ADDR_BW-1:0]                next_addr_s;

  result_deskew #(
    .LANE_BW (PARTIAL_SUM_BW),
    .LANES   (MATRIX_SIZE)
  ) u_deskew (
    .clk           (clk),
    .rstn          (rstn),
    .valid_in      (result_valid),
    .data_in       (result_in),
    .aligned_valid (al_valid_s),
    .aligned_data  (al_data_s)
  );

  // Row presented to SRAM; negative lanes are zeroed when ReLU is built in.
  function automatic logic [ROW_W-1:0] drain_row(input logic [ROW_W-1:0] row);
    logic [ROW_W-1:0] out_v;
    out_v = row;
`ifdef RESULT_ACC_RELU_EN
    for (int c = 0; c < MATRIX_SIZE; c++) begin
      if (row[c*ACC_BW + ACC_BW - 1]) begin
        out_v[c*ACC_BW +: ACC_BW] = '0;
      end else begin
        out_v[c*ACC_BW +: ACC_BW] = row[c*ACC_BW +: ACC_BW];
      end
    end
`endif
    return out_v;
  endfunction

  assign cur_row_s   = bank_r[row_cnt_r];
  assign next_addr_s = wr_addr_r + ADDR_BW'(1);

  for (genvar c = 0; c < MATRIX_SIZE; c++) begin : g_sat
    localparam int PLSB = lane_lsb(c, PARTIAL_SUM_BW);
    localparam int ALSB = lane_lsb(c, ACC_BW);
    logic signed [SAT_W-1:0] x_s;
    logic signed [SAT_W-1:0] a_s;
    logic signed [SAT_W-1:0] r_s;

    // Sign-extend the incoming lane and the stored lane, then saturate the sum.
    always_comb begin
      x_s = {{(SAT_W-PARTIAL_SUM_BW){al_data_s[PLSB+PARTIAL_SUM_BW-1]}},
             al_data_s[PLSB +: PARTIAL_SUM_BW]};
      if (clear_r) begin
        a_s = '0;
      end else begin
        a_s = {{(SAT_W-ACC_BW){cur_row_s[ALSB+ACC_BW-1]}}, cur_row_s[ALSB +: ACC_BW]};
      end
      r_s = sat_add(a_s, x_s, ACC_BW);
    end

    assign bank_wdata_s[ALSB +: ACC_BW] = r_s[ACC_BW-1:0];
  end

  // Bank write only for aligned rows that arrive while collecting.
  always_comb begin
    bank_we_s = 1'b0;
    if ((state_r == ST_COLLECT) && al_valid_s) begin
      bank_we_s = 1'b1;
    end else begin
      bank_we_s = 1'b0;
    end
  end

  // Accumulator bank storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ACC_DEPTH; i++) bank_r[i] <= '0;
    end else if (bank_we_s) begin
      bank_r[row_cnt_r] <= bank_wdata_s;
    end
  end

  // Control FSM with registered SRAM port and status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      row_cnt_r   <= '0;
      clear_r     <= 1'b0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      busy_r      <= 1'b0;
      tile_done_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      tile_done_r <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r   <= ST_COLLECT;
            row_cnt_r <= '0;
            clear_r   <= acc_clear;
            busy_r    <= 1'b1;
          end else if (drain) begin
            state_r   <= ST_DRAIN;
            wr_en_r   <= 1'b1;
            wr_addr_r <= '0;
            wr_data_r <= drain_row(bank_r[0]);
            busy_r    <= 1'b1;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (al_valid_s) begin
            if (row_cnt_r == LAST_ROW) begin
              state_r     <= ST_IDLE;
              row_cnt_r   <= '0;
              busy_r      <= 1'b0;
              tile_done_r <= 1'b1;
            end else begin
              row_cnt_r   <= row_cnt_r + ADDR_BW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (wr_addr_r == LAST_ROW) begin
            state_r   <= ST_IDLE;
            wr_en_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
          end else begin
            wr_addr_r <= next_addr_s;
            wr_data_r <= drain_row(bank_r[next_addr_s]);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          wr_en_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en     = wr_en_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign busy      = busy_r;
  assign tile_done = tile_done_r;
  assign done      = done_r;

endmodule
